multdiv_sequencer: RTL and testbench

Sequences the multi-cycle multiplier/divider for the 5-stage pipelined processor and arbitrates the single register-file write port between the MW stage and late multdiv results. It latches operands at issue, pulses the multdiv start controls, and holds the execute-stage stall until the result has retired. It buffers the result until the write port is free and converts multdiv exceptions into an `r30` status write. It sits between the DX stage, the `multdiv` unit and the register-file write port.

---
 rtl/multdiv_seq_pkg.sv | 23 ++
 rtl/multdiv_sequencer.sv | 137 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_seq_pkg.sv
// multdiv_seq_pkg: shared types and constants for the multdiv sequencer.
// State encoding, status register index and exception status codes.
package multdiv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WRITE = 2'd3
  } md_state_e;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] RS_MULT_OVF = 32'd4;
  localparam logic [31:0] RS_DIV_EXC  = 32'd5;
  localparam logic [31:0] RS_WATCHDOG = 32'd6;

  function automatic logic [31:0] exc_code(
    input logic is_div
  );
    return is_div ? RS_DIV_EXC : RS_MULT_OVF;
  endfunction

endpackage

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mult/div to multdiv, stalls DX, and merges the
// late result into the regfile write port behind MW-stage writes.
// Ports: clock/reset (sync, active-high); issue_* from DX; busy stall;
// md_* to/from multdiv; pipe_* MW write request; ctrl_*/data_writeReg
// to the register file. Optional MULTDIV_WATCHDOG_EN aborts a hung
// BUSY after WATCHDOG_CYCLES cycles with status code 6 in r30.
module multdiv_sequencer
  import multdiv_seq_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        busy,
  output logic        md_done,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wreg,
  input  logic [31:0] pipe_wdata,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  md_state_e   state;
  logic        op_div;
  logic [4:0]  op_rd;
  logic [31:0] hold_data;
  logic        hold_exc;

`ifdef MULTDIV_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(WATCHDOG_CYCLES - 1);
  logic [7:0] wd_cnt;
`else
  logic [7:0] unused_wd;
  assign unused_wd = 8'(WATCHDOG_CYCLES);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      op_div       <= 1'b0;
      op_rd        <= '0;
      hold_data    <= '0;
      hold_exc     <= 1'b0;
`ifdef MULTDIV_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue_valid) begin
            state        <= START;
            busy         <= 1'b1;
            md_ctrl_MULT <= ~issue_div;
            md_ctrl_DIV  <= issue_div;
            md_operandA  <= issue_a;
            md_operandB  <= issue_b;
            op_div       <= issue_div;
            op_rd        <= issue_rd;
          end
        end
        START: begin
          state <= BUSY;
`ifdef MULTDIV_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        BUSY: begin
          // Ready beats the watchdog when both land on the same edge.
          if (md_resultRDY) begin
            state     <= WRITE;
            hold_exc  <= md_exception;
            hold_data <= md_exception ? exc_code(op_div)
                                      : md_result;
          end
`ifdef MULTDIV_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state     <= WRITE;
            hold_exc  <= 1'b1;
            hold_data <= RS_WATCHDOG;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        WRITE: begin
          if (!pipe_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline owns the port; the held result only drains on a free cycle.
  always_comb begin
    ctrl_writeEnable = pipe_we;
    ctrl_writeReg    = pipe_wreg;
    data_writeReg    = pipe_wdata;
    md_done          = 1'b0;
    if (state == WRITE && !pipe_we) begin
      md_done          = 1'b1;
      ctrl_writeEnable = hold_exc | (op_rd != 5'd0);
      ctrl_writeReg    = hold_exc ? RSTATUS_REG : op_rd;
      data_writeReg    = hold_data;
    end
    if (reset) begin
      ctrl_writeEnable = 1'b0;
      md_done          = 1'b0;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed vector table plus hand sequences for
// pipe conflicts, reset during BUSY and the watchdog path.
module tb_multdiv_sequencer;

  localparam int WD = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        busy;
  logic        md_done;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        pipe_we;
  logic [4:0]  pipe_wreg;
  logic [31:0] pipe_wdata;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  multdiv_sequencer #(.WATCHDOG_CYCLES(WD)) dut (
    .clock            (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_div        (issue_div),
    .issue_rd         (issue_rd),
    .issue_a          (issue_a),
    .issue_b          (issue_b),
    .busy             (busy),
    .md_done          (md_done),
    .md_operandA      (md_operandA),
    .md_operandB      (md_operandB),
    .md_ctrl_MULT     (md_ctrl_MULT),
    .md_ctrl_DIV      (md_ctrl_DIV),
    .md_result        (md_result),
    .md_exception     (md_exception),
    .md_resultRDY     (md_resultRDY),
    .pipe_we          (pipe_we),
    .pipe_wreg        (pipe_wreg),
    .pipe_wdata       (pipe_wdata),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mult_p = 0;
  int div_p = 0;
  int done_p = 0;

  always @(negedge clk) begin
    if (md_ctrl_MULT) mult_p++;
    if (md_ctrl_DIV) div_p++;
    if (md_done) done_p++;
  end

  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int m0;
    int d0;
    int n0;
    string t;
    t = $sformatf("v%0d", idx);
    m0 = mult_p;
    d0 = div_p;
    n0 = done_p;
    issue_valid = 1'b1;
    issue_div = v.is_div;
    issue_rd = v.rd;
    issue_a = v.a;
    issue_b = v.b;
    step();
    issue_valid = 1'b0;
    issue_a = ~v.a;
    issue_b = ~v.b;
    #1;
    chk({t, "_start_busy"}, 32'(busy), 32'd1);
    chk({t, "_opA"}, md_operandA, v.a);
    chk({t, "_opB"}, md_operandB, v.b);
    chk({t, "_mult"}, 32'(md_ctrl_MULT), 32'(!v.is_div));
    chk({t, "_div"}, 32'(md_ctrl_DIV), 32'(v.is_div));
    step();
    for (int i = 0; i < v.lat - 1; i++) step();
    chk({t, "_busy_wait"}, 32'(busy), 32'd1);
    chk({t, "_opA_hold"}, md_operandA, v.a);
    md_resultRDY = 1'b1;
    md_result = v.res;
    md_exception = v.exc;
    step();
    md_resultRDY = 1'b0;
    md_result = 32'hDEAD_BEEF;
    md_exception = 1'b0;
    #1;
    chk({t, "_we"}, 32'(ctrl_writeEnable), 32'(v.exp_we));
    if (v.exp_we) begin
      chk({t, "_reg"}, 32'(ctrl_writeReg), 32'(v.exp_reg));
      chk({t, "_data"}, data_writeReg, v.exp_data);
    end
    chk({t, "_done"}, 32'(md_done), 32'd1);
    chk({t, "_wr_busy"}, 32'(busy), 32'd1);
    step();
    #1;
    chk({t, "_idle_busy"}, 32'(busy), 32'd0);
    chk({t, "_done_off"}, 32'(md_done), 32'd0);
    chk({t, "_nmult"}, 32'(mult_p - m0), 32'(!v.is_div));
    chk({t, "_ndiv"}, 32'(div_p - d0), 32'(v.is_div));
    chk({t, "_ndone"}, 32'(done_p - n0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd5, 32'd6, 32'd7, 32'd42,
                1'b0, 32, 1'b1, 5'd5, 32'd42};
    vecs[1] = '{1'b1, 5'd9, 32'd7, 32'd0, 32'hFFFF_FFFF,
                1'b1, 32, 1'b1, 5'd30, 32'd5};
    vecs[2] = '{1'b0, 5'd0, 32'd3, 32'd5, 32'd15,
                1'b0, 4, 1'b0, 5'd0, 32'd0};
    vecs[3] = '{1'b0, 5'd7, 32'h1_0000, 32'h1_0000, 32'd0,
                1'b1, 8, 1'b1, 5'd30, 32'd4};
    vecs[4] = '{1'b1, 5'd12, 32'd100, 32'd7, 32'd14,
                1'b0, 5, 1'b1, 5'd12, 32'd14};
    vecs[5] = '{1'b0, 5'd0, 32'd9, 32'd9, 32'd81,
                1'b1, 2, 1'b1, 5'd30, 32'd4};

    reset = 1'b1;
    issue_valid = 1'b0;
    issue_div = 1'b0;
    issue_rd = '0;
    issue_a = '0;
    issue_b = '0;
    md_result = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    pipe_we = 1'b1;
    pipe_wreg = 5'd3;
    pipe_wdata = 32'd5;
    repeat (3) step();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_mult", 32'(md_ctrl_MULT), 32'd0);
    chk("rst_div", 32'(md_ctrl_DIV), 32'd0);
    chk("rst_opA", md_operandA, 32'd0);
    chk("rst_opB", md_operandB, 32'd0);
    chk("rst_we_forced", 32'(ctrl_writeEnable), 32'd0);
    reset = 1'b0;
    #1;
    chk("pass_we", 32'(ctrl_writeEnable), 32'd1);
    chk("pass_reg", 32'(ctrl_writeReg), 32'd3);
    chk("pass_data", data_writeReg, 32'd5);
    pipe_we = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Pipe writes hold off the result for three cycles.
    issue_valid = 1'b1;
    issue_div = 1'b0;
    issue_rd = 5'd4;
    issue_a = 32'd2;
    issue_b = 32'd3;
    step();
    issue_valid = 1'b0;
    step();
    step();
    step();
    md_resultRDY = 1'b1;
    md_result = 32'd6;
    step();
    md_resultRDY = 1'b0;
    md_result = '0;
    for (int k = 0; k < 3; k++) begin
      pipe_we = 1'b1;
      pipe_wreg = 5'd3;
      pipe_wdata = 32'h11 * (k + 1);
      #1;
      chk("cf_pipe_we", 32'(ctrl_writeEnable), 32'd1);
      chk("cf_pipe_reg", 32'(ctrl_writeReg), 32'd3);
      chk("cf_pipe_data", data_writeReg, 32'h11 * (k + 1));
      chk("cf_done_low", 32'(md_done), 32'd0);
      chk("cf_busy", 32'(busy), 32'd1);
      step();
    end
    pipe_we = 1'b0;
    #1;
    chk("cf_md_we", 32'(ctrl_writeEnable), 32'd1);
    chk("cf_md_reg", 32'(ctrl_writeReg), 32'd4);
    chk("cf_md_data", data_writeReg, 32'd6);
    chk("cf_md_done", 32'(md_done), 32'd1);
    step();
    chk("cf_idle", 32'(busy), 32'd0);

    // Reset during BUSY discards the late result.
    issue_valid = 1'b1;
    issue_div = 1'b1;
    issue_rd = 5'd6;
    issue_a = 32'd50;
    issue_b = 32'd5;
    step();
    issue_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    pipe_we = 1'b1;
    pipe_wreg = 5'd2;
    pipe_wdata = 32'hAB;
    #1;
    chk("rb_we_forced", 32'(ctrl_writeEnable), 32'd0);
    step();
    reset = 1'b0;
    pipe_we = 1'b0;
    #1;
    chk("rb_busy_off", 32'(busy), 32'd0);
    md_resultRDY = 1'b1;
    md_result = 32'd77;
    step();
    md_resultRDY = 1'b0;
    #1;
    chk("rb_stale_busy", 32'(busy), 32'd0);
    chk("rb_stale_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rb_stale_done", 32'(md_done), 32'd0);
    step();
    chk("rb_stale_we2", 32'(ctrl_writeEnable), 32'd0);
    run_vec(vecs[4], 6);

    // Ready never arrives.
    issue_valid = 1'b1;
    issue_div = 1'b0;
    issue_rd = 5'd8;
    issue_a = 32'd1;
    issue_b = 32'd1;
    step();
    issue_valid = 1'b0;
    step();
    repeat (WD - 1) step();
    #1;
    chk("wd_busy10", 32'(busy), 32'd1);
    chk("wd_no_wr10", 32'(ctrl_writeEnable), 32'd0);
    step();
    #1;
`ifdef MULTDIV_WATCHDOG_EN
    chk("wd_we", 32'(ctrl_writeEnable), 32'd1);
    chk("wd_reg", 32'(ctrl_writeReg), 32'd30);
    chk("wd_data", data_writeReg, 32'd6);
    chk("wd_done", 32'(md_done), 32'd1);
    step();
    chk("wd_idle", 32'(busy), 32'd0);
`else
    chk("nowd_we", 32'(ctrl_writeEnable), 32'd0);
    chk("nowd_busy", 32'(busy), 32'd1);
    repeat (40) step();
    chk("nowd_busy_long", 32'(busy), 32'd1);
    chk("nowd_done", 32'(md_done), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("nowd_recover", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
